// File: rtl/lsa_adc_scanner.sv
// Round-robin 4-channel serial ADC front end: one fixed-length frame per channel, 12-bit MSB-first capture.
// Optional macro LSA_VALID_EN adds a one-cycle data_valid strobe and the valid_ch channel tag.
module lsa_adc_scanner #(
    parameter int FRAME_LEN    = 20,
    parameter int SAMPLE_START = 7,
    parameter int DATA_W       = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ADC1,
    input  logic              ADC2,
    input  logic              ADC3,
    input  logic              ADC4,
    output logic              cs,
    output logic              din,
    output logic [7:0]        count,
    output logic [1:0]        ch_idx,
    output logic [DATA_W-1:0] data_out
`ifdef LSA_VALID_EN
    ,
    output logic              data_valid,
    output logic [1:0]        valid_ch
`endif
);

    localparam logic [7:0] LAST_CNT     = 8'(FRAME_LEN - 1);
    localparam logic [7:0] SAMPLE_FIRST = 8'(SAMPLE_START);
    localparam logic [7:0] SAMPLE_LAST  = 8'(SAMPLE_START + DATA_W - 1);
    localparam logic [7:0] UPDATE_CNT   = 8'(SAMPLE_START + DATA_W);

    generate
        if (FRAME_LEN < 16 || FRAME_LEN > 255 || (SAMPLE_START + DATA_W) > (FRAME_LEN - 1)) begin : g_bad_params
            $fatal(1, "lsa_adc_scanner: illegal FRAME_LEN/SAMPLE_START/DATA_W combination");
        end
    endgenerate

    logic [7:0]        count_nxt_s;
    logic [1:0]        ch_nxt_s;
    logic              din_nxt_s;
    logic              adc_bit_s;
    logic              sample_s;
    logic              update_s;
    logic [DATA_W-1:0] shift_r;

    // Frame position and channel for the next cycle.
    always_comb begin
        count_nxt_s = 8'd0;
        ch_nxt_s    = ch_idx;
        if (count == LAST_CNT) begin
            count_nxt_s = 8'd0;
            ch_nxt_s    = ch_idx + 2'd1;
        end else begin
            count_nxt_s = count + 8'd1;
            ch_nxt_s    = ch_idx;
        end
    end

    // Serial input select for the channel in progress.
    always_comb begin
        adc_bit_s = 1'b0;
        case (ch_idx)
            2'd0:    adc_bit_s = ADC1;
            2'd1:    adc_bit_s = ADC2;
            2'd2:    adc_bit_s = ADC3;
            2'd3:    adc_bit_s = ADC4;
            default: adc_bit_s = 1'b0;
        endcase
    end

    // Address bits are computed from next-cycle position so the registered din lines up with count.
    always_comb begin
        din_nxt_s = 1'b0;
        case (count_nxt_s)
            8'd2:    din_nxt_s = ch_nxt_s[1];
            8'd3:    din_nxt_s = ch_nxt_s[0];
            default: din_nxt_s = 1'b0;
        endcase
    end

    // Sampling window and word-update strobes for the current cycle.
    always_comb begin
        sample_s = (count >= SAMPLE_FIRST) && (count <= SAMPLE_LAST);
        update_s = (count == UPDATE_CNT);
    end

    // Frame sequencer, chip-select/address generation and sample capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= 8'd0;
            ch_idx   <= 2'd0;
            cs       <= 1'b1;
            din      <= 1'b0;
            shift_r  <= {DATA_W{1'b0}};
            data_out <= {DATA_W{1'b0}};
        end else begin
            count  <= count_nxt_s;
            ch_idx <= ch_nxt_s;
            cs     <= (count_nxt_s == 8'd0);
            din    <= din_nxt_s;
            if (sample_s) begin
                shift_r <= {shift_r[DATA_W-2:0], adc_bit_s};
            end else begin
                shift_r <= shift_r;
            end
            if (update_s) begin
                data_out <= shift_r;
            end else begin
                data_out <= data_out;
            end
        end
    end

`ifdef LSA_VALID_EN
    // Valid strobe coincides with the first cycle the new word is visible; valid_ch tags that word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_valid <= 1'b0;
            valid_ch   <= 2'd0;
        end else begin
            data_valid <= update_s;
            if (update_s) begin
                valid_ch <= ch_idx;
            end else begin
                valid_ch <= valid_ch;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsa_adc_scanner.sv
// Scoreboard bench for lsa_adc_scanner: random serial words per frame, frame-arithmetic reference model.
module tb_lsa_adc_scanner;

    localparam int FL  = 20;
    localparam int SS  = 7;
    localparam int DW  = 12;
    localparam int UPD = SS + DW;

    typedef struct {
        logic [1:0]    ch;
        logic [DW-1:0] word;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    adc;
    logic          cs;
    logic          din;
    logic [7:0]    count;
    logic [1:0]    ch_idx;
    logic [DW-1:0] data_out;
`ifdef LSA_VALID_EN
    logic          data_valid;
    logic [1:0]    valid_ch;
`endif

    int            total = 0;
    int            bad   = 0;
    int            t     = 0;
    exp_t          sb_q[$];
    logic [DW-1:0] cur_word  = '0;
    logic [DW-1:0] prev_word = '0;
    logic          have_prev = 1'b0;
    logic          rst_q;
    logic [DW-1:0] fixed_words [4] = '{12'h736, 12'h676, 12'h6B6, 12'h6A6};

    always #5 clk = ~clk;

    lsa_adc_scanner dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ADC1     (adc[0]),
        .ADC2     (adc[1]),
        .ADC3     (adc[2]),
        .ADC4     (adc[3]),
        .cs       (cs),
        .din      (din),
        .count    (count),
        .ch_idx   (ch_idx),
        .data_out (data_out)
`ifdef LSA_VALID_EN
        ,
        .data_valid (data_valid),
        .valid_ch   (valid_ch)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d: got 0x%0h expected 0x%0h", name, t, act, exp);
        end
    endtask

    // Hold reset for the given number of cycles, check reset state, then release at a negedge.
    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        adc   = 4'($urandom);
        repeat (hold) @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ch_idx", 32'(ch_idx), 32'd0);
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        rst_n     = 1'b1;
        t         = 0;
        have_prev = 1'b0;
        cur_word  = '0;
        prev_word = '0;
    endtask

    // Model: position and channel follow directly from cycles elapsed since reset release.
    task automatic run(input int ncyc, input bit use_fixed);
        for (int n = 0; n < ncyc; n++) begin
            int p;
            int f;
            logic [1:0] ch;
            logic exp_din;
            p  = t % FL;
            f  = t / FL;
            ch = 2'(f % 4);
            if (p == 0) begin
                if (f > 0) begin
                    prev_word = cur_word;
                    have_prev = 1'b1;
                end
                cur_word = (use_fixed && f < 4) ? fixed_words[f] : DW'($urandom);
            end
            exp_din = (p == 2) ? ch[1] : ((p == 3) ? ch[0] : 1'b0);
            chk("count", 32'(count), 32'(p));
            chk("ch_idx", 32'(ch_idx), 32'(ch));
            chk("cs", 32'(cs), 32'(p == 0));
            chk("din", 32'(din), 32'(exp_din));
            chk("data_out_hold", 32'(data_out), have_prev ? 32'(prev_word) : 32'd0);
            adc = 4'($urandom);
            if (p >= SS && p < SS + DW) begin
                adc[ch] = cur_word[DW-1-(p-SS)];
            end
            if (p == SS + DW - 1) begin
                sb_q.push_back('{ch, cur_word});
            end
            @(negedge clk);
            t++;
        end
    endtask

    always @(posedge clk) rst_q <= rst_n;

    // Monitor: a word is presented on the cycle after the DUT sat at the update count out of reset.
    initial begin
        logic [7:0] prev_cnt;
        logic [1:0] prev_ch;
        exp_t       e;
        logic       ev;
        prev_cnt = 8'd0;
        prev_ch  = 2'd0;
        forever begin
            @(negedge clk);
            ev = (rst_q === 1'b1) && (prev_cnt == 8'(UPD));
            if (ev) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow t=%0d: got word 0x%0h expected none", t, data_out);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_word", 32'(data_out), 32'(e.word));
                    chk("sb_ch", 32'(prev_ch), 32'(e.ch));
`ifdef LSA_VALID_EN
                    chk("valid_ch", 32'(valid_ch), 32'(e.ch));
`endif
                end
            end
`ifdef LSA_VALID_EN
            chk("data_valid", 32'(data_valid), 32'(ev));
`endif
            prev_cnt = count;
            prev_ch  = ch_idx;
        end
    end

    initial begin
        rst_n = 1'b0;
        adc   = 4'd0;
        do_reset(3);
        run(6 * FL, 1'b1);
        do_reset(2);
        run(FL + 12, 1'b1);
        do_reset(1);
        run(5 * FL, 1'b1);
        do_reset(1);
        run(16 * FL, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsa_adc_scanner.md
Name: lsa_adc_scanner

Overview:
- Serial front end for the 4-channel line-sensor-array (LSA) ADC path.
- Runs a fixed-length conversion frame per channel, round-robin over channels 0..3.
- Each frame drives chip-select and the channel address, then shifts in a 12-bit sample MSB-first from that channel's serial data line.
- Presents the last completed word with its channel index to downstream steering logic.

Parameters:
- FRAME_LEN, 20: clock cycles per channel frame; range 16..255.
- SAMPLE_START, 7: count value at which the first (MSB) data bit is sampled.
- DATA_W, 12: sample width in bits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- ADC1  input  1  serial data, channel 0.
- ADC2  input  1  serial data, channel 1.
- ADC3  input  1  serial data, channel 2.
- ADC4  input  1  serial data, channel 3.
- cs  output  1  converter chip-select, active-low.
- din  output  1  serial channel-address line to the converter.
- count  output  8  cycle position within the current frame.
- ch_idx  output  2  channel of the frame in progress.
- data_out  output  DATA_W  last completed sample.

Behaviour:
- Reset values (rst_n low at a rising edge): count=0, ch_idx=0, cs=1, din=0, data_out=0, internal shift register=0.
- The first rising edge with rst_n high is frame cycle count=0, channel 0.
- count: increments every cycle. Wraps from FRAME_LEN-1 to 0. All outputs are registered.
- ch_idx: increments on the count wrap and wraps from 3 to 0.
- cs: high when count==0, low for count 1..FRAME_LEN-1. This gives one idle-high cycle per frame.
- din: ch_idx[1] while count==2, ch_idx[0] while count==3, 0 at all other times.
- Input select: combinational mux picks ADC(ch_idx+1).
- Sampling: on count = SAMPLE_START .. SAMPLE_START+DATA_W-1, shift the selected bit into the LSB of the shift register (shift left). The first bit sampled ends up as the MSB.
- Update: on count = SAMPLE_START+DATA_W (=19 by default), data_out <= shift register. data_out then holds until the next update.
- Latency: data_out becomes valid one cycle after the last data bit.
- ch_idx during the update cycle still names the channel whose word was loaded. ch_idx advances on the following cycle.
- Inputs are not sampled outside the sampling window. Values on an unselected channel are ignored.
- Reset mid-frame: the partial sample is discarded, data_out clears to 0, and scanning restarts at channel 0, count 0.
- Parameter legality: SAMPLE_START+DATA_W must be ≤ FRAME_LEN-1. This is checked at elaboration; an illegal combination is a fatal error.

Optional Feature:
- Macro LSA_VALID_EN.
- Defined:
  - Adds output data_valid (1 bit, reset 0).
  - data_valid pulses high for exactly one cycle, the cycle after data_out updates.
  - Adds output valid_ch (2 bits, reset 0), holding the channel of the word in data_out.
- Undefined: neither port exists; the rest of the behaviour is identical.

Test Plan:
- Reset: hold rst_n low 3 cycles, then release -> count=0, ch_idx=0, cs=1, data_out=0. From the first count=1 onward cs=0. cs rises again when count returns to 0 (cycle 20).
- Frame 0: ADC1 presents bits 0,1,1,1,0,0,1,1,0,1,1,0, one per cycle, sampled at count 7..18 -> data_out=0x736 after count 19, with ch_idx=0.
- Round-robin:
  - Frames 1..3 feed ADC2=0,1,1,0,0,1,1,1,0,1,1,0; ADC3=0,1,1,0,1,0,1,1,0,1,1,0; ADC4=0,1,1,0,1,0,1,0,0,1,1,0.
  - Expected data_out: 0x676, 0x6B6, 0x6A6 in turn.
  - ch_idx reads 1, 2, 3, then wraps to 0 at frame 4.
- Channel isolation: toggle ADC2..ADC4 randomly during frame 0 -> data_out still 0x736. Toggle ADC1 outside count 7..18 -> no change in the result.
- Address line: during frame 2, din=1 at count 2 and din=0 at count 3. din=0 at every other count.
- Mid-frame reset: assert rst_n low at count 12 of frame 1 -> data_out=0 and ch_idx=0. The next completed word comes from ADC1. With LSA_VALID_EN defined, there is exactly one data_valid pulse per frame, and valid_ch matches the frame's channel.
